pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Top-level game sequencer for the ping-pong design. It directly drives the 7-bit countdown timer through `timer_start` and consumes that timer's `timer_up`. It also sequences new game, serve, play, and game-over phases, keeps the 2-digit BCD score and the balls-remaining count, and freezes the graphics between rallies. It sits between the debounced buttons and ball-collision flags on one side, and the timer, graphics and text overlay on the other.

## Interface
- `BALLS`, default 3: balls per game. Legal range is 1..7.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. Asserts immediately; released synchronously by the system reset bridge.
- `btn`  in  2: debounced player buttons, level. The start/serve event is a rising edge of `|btn`.
- `hit`  in  1: one-cycle pulse. Ball struck a paddle.
- `miss`  in  1: one-cycle pulse. Ball passed a paddle.
- `timer_up`  in  1: level from the countdown timer. High while the timer is at 0.
- `timer_start`  out  1: one-cycle pulse that reloads the timer to 127.
- `gra_still`  out  1: 1 freezes ball motion in the graphics.
- `game_state`  out  2: current state code, used by the text overlay.
- `balls_left`  out  3: balls remaining.
- `score_d1`, `score_d0`  out  4 each: BCD score, tens and units.
- `hiscore_d1`, `hiscore_d0`  out  4 each: high score. Present only when `PONG_HISCORE_EN` is defined.

## Operation
- States and codes: NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3.
- `btn_ev` is the rising edge of `|btn`, taken against a 1-bit registered copy of `|btn`.
- NEWGAME:
  - `gra_still`=1, score held at 00, `balls_left`=`BALLS`.
  - On `btn_ev`, go to PLAY and decrement `balls_left`.
- PLAY:
  - `gra_still`=0.
  - `hit`: score increments by 1 in BCD. 09 goes to 10, and 99 wraps to 00.
  - `miss` with `balls_left`=0: go to OVER and pulse `timer_start`.
  - `miss` with `balls_left`>0: go to NEWBALL, pulse `timer_start`, and decrement `balls_left`.
  - If `hit` and `miss` arrive in the same cycle, `hit` wins and `miss` is ignored.
- NEWBALL:
  - `gra_still`=1.
  - Go to PLAY when `timer_up` and `btn_ev` are both high in the same cycle.
  - A `btn_ev` before timer expiry is discarded and not queued.
- OVER:
  - `gra_still`=1.
  - Go to NEWGAME when `timer_up` is high.
  - On entry to NEWGAME, clear the score to 00 and reload `balls_left` to `BALLS`.
- Stale-timer guard: in NEWBALL and OVER, `timer_up` is ignored in any cycle where `timer_start` is high. The timer has not reloaded yet in that cycle.
- `hit` and `miss` are ignored outside PLAY.
- `balls_left` never underflows. It is only decremented when it is nonzero.

## Timing
- All outputs are registered.
- Reset values: state NEWGAME, `gra_still`=1, `timer_start`=0, `game_state`=0, `balls_left`=`BALLS`, score 00, high score 00, edge register 0.
- Input to state change latency is 1 cycle. The state and its outputs update on the edge that samples the input.
- `timer_start` is high for exactly the first cycle spent in NEWBALL or OVER.
- A score update is visible on `score_d*` one cycle after the `hit` cycle.
- Minimum NEWBALL/OVER dwell is 128 timer ticks plus 1 clock.
- An async reset mid-game returns to NEWGAME at once. No pending `timer_start` is emitted.

## Configuration
- `PONG_HISCORE_EN` defined:
  - On the PLAY to OVER transition, if the score exceeds the high score, copy the score into the high score.
  - The high score is cleared only by `reset_n`.
  - The `hiscore_d1` and `hiscore_d0` ports exist.
- `PONG_HISCORE_EN` undefined: the high-score register, the compare logic and the `hiscore_*` ports are omitted.

## Structure
- Shared package `pong_pkg` holds:
  - the state codes: `ST_NEWGAME`, `ST_PLAY`, `ST_NEWBALL`, `ST_OVER`;
  - the BCD digit width (4);
  - the timer reload value (127).
- Sub-module `bcd_score_counter`:
  - 2-digit BCD counter with synchronous `clr` and `inc` and wrap 99 to 00;
  - reused for any future second-player score.
- The FSM, edge detector, ball counter and high-score register stay in `pong_game_ctrl`.

## Test plan
- Reset: hold `reset_n`=0 → state 0, `gra_still`=1, `balls_left`=3, score 00. Then `btn`=01 → PLAY next cycle, `balls_left`=2.
- Scoring wrap: in PLAY, 100 `hit` pulses → score steps 00..99 then 00. Pulse 10 gives `score_d1`=1, `score_d0`=0.
- Miss and serve: `miss` with `balls_left`=2 → NEWBALL, one-cycle `timer_start`, `balls_left`=1. `btn_ev` before `timer_up` → stays NEWBALL. `btn_ev` with `timer_up` → PLAY.
- Stale timer: `timer_up` held 1 across the `timer_start` cycle in OVER → no exit that cycle. Exit only on a later `timer_up`, then NEWGAME with score 00 and `balls_left`=3.
- Simultaneous `hit` and `miss` in PLAY → score +1, state stays PLAY, `balls_left` unchanged.
- With `PONG_HISCORE_EN`: game 1 ends at 05, game 2 ends at 03 → high score 05. Assert `reset_n` mid-PLAY → high score 00, state NEWGAME.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong game controller slice:
// state codes, BCD digit width and the countdown timer reload value.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam int BCD_W = 4;

    localparam logic [6:0] TIMER_RELOAD = 7'd127;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter, synchronous clear and increment, 99 wraps to 00.
// Ports: clk, reset_n (async low), clr, inc -> d1 (tens), d0 (units).
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] d1,
    output logic [BCD_W-1:0] d0
);

    logic [BCD_W-1:0] r_d1;
    logic [BCD_W-1:0] r_d0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1 <= '0;
            r_d0 <= '0;
        end else if (clr) begin
            r_d1 <= '0;
            r_d0 <= '0;
        end else if (inc) begin
            if (r_d0 == 4'd9) begin
                r_d0 <= '0;
                r_d1 <= (r_d1 == 4'd9) ? '0 : r_d1 + 4'd1;
            end else begin
                r_d0 <= r_d0 + 4'd1;
            end
        end
    end

    assign d1 = r_d1;
    assign d0 = r_d0;

endmodule

// File: rtl/pong_game_ctrl.sv
// Ping-pong game sequencer: new game / play / new ball / game over,
// ball count, BCD score, timer start pulse and graphics freeze.
// Ports: clk, reset_n, btn[1:0], hit, miss, timer_up in;
//   timer_start, gra_still, game_state, balls_left, score_d1/d0 out.
// PONG_HISCORE_EN adds a high-score register and hiscore_d1/d0 outputs.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       btn,
    input  logic             hit,
    input  logic             miss,
    input  logic             timer_up,
    output logic             timer_start,
    output logic             gra_still,
    output logic [1:0]       game_state,
    output logic [2:0]       balls_left,
`ifdef PONG_HISCORE_EN
    output logic [BCD_W-1:0] hiscore_d1,
    output logic [BCD_W-1:0] hiscore_d0,
`endif
    output logic [BCD_W-1:0] score_d1,
    output logic [BCD_W-1:0] score_d0
);

    localparam logic [2:0] BALLS_INIT = 3'(BALLS);

    state_t     r_state;
    logic       r_btn_q;
    logic       r_timer_start;
    logic       r_gra_still;
    logic [2:0] r_balls;

    logic       w_btn_ev;
    logic       w_timer_ok;
    logic       w_score_clr;
    logic       w_score_inc;
    logic [BCD_W-1:0] w_sc_d1;
    logic [BCD_W-1:0] w_sc_d0;

    assign w_btn_ev = (|btn) & ~r_btn_q;

    // Timer has not reloaded yet while our start pulse is still out.
    assign w_timer_ok = timer_up & ~r_timer_start;

    assign w_score_clr = (r_state == ST_OVER) & w_timer_ok;
    assign w_score_inc = (r_state == ST_PLAY) & hit;

`ifdef PONG_HISCORE_EN
    logic [BCD_W-1:0] r_hi_d1;
    logic [BCD_W-1:0] r_hi_d0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_NEWGAME;
            r_btn_q       <= 1'b0;
            r_timer_start <= 1'b0;
            r_gra_still   <= 1'b1;
            r_balls       <= BALLS_INIT;
`ifdef PONG_HISCORE_EN
            r_hi_d1       <= '0;
            r_hi_d0       <= '0;
`endif
        end else begin
            r_btn_q       <= |btn;
            r_timer_start <= 1'b0;
            unique case (r_state)
                ST_NEWGAME: begin
                    if (w_btn_ev) begin
                        r_state     <= ST_PLAY;
                        r_gra_still <= 1'b0;
                        if (r_balls != 3'd0)
                            r_balls <= r_balls - 3'd1;
                    end
                end
                ST_PLAY: begin
                    // A simultaneous hit takes priority over the miss.
                    if (miss && !hit) begin
                        r_timer_start <= 1'b1;
                        r_gra_still   <= 1'b1;
                        if (r_balls == 3'd0) begin
                            r_state <= ST_OVER;
`ifdef PONG_HISCORE_EN
                            // BCD digits compare correctly as a packed byte.
                            if ({w_sc_d1, w_sc_d0} > {r_hi_d1, r_hi_d0}) begin
                                r_hi_d1 <= w_sc_d1;
                                r_hi_d0 <= w_sc_d0;
                            end
`endif
                        end else begin
                            r_state <= ST_NEWBALL;
                            r_balls <= r_balls - 3'd1;
                        end
                    end
                end
                ST_NEWBALL: begin
                    if (w_timer_ok && w_btn_ev) begin
                        r_state     <= ST_PLAY;
                        r_gra_still <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (w_timer_ok) begin
                        r_state <= ST_NEWGAME;
                        r_balls <= BALLS_INIT;
                    end
                end
            endcase
        end
    end

    bcd_score_counter u_score (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_score_clr),
        .inc     (w_score_inc),
        .d1      (w_sc_d1),
        .d0      (w_sc_d0)
    );

    assign timer_start = r_timer_start;
    assign gra_still   = r_gra_still;
    assign game_state  = r_state;
    assign balls_left  = r_balls;
    assign score_d1    = w_sc_d1;
    assign score_d0    = w_sc_d0;
`ifdef PONG_HISCORE_EN
    assign hiscore_d1  = r_hi_d1;
    assign hiscore_d0  = r_hi_d0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (BALLS=3).
// Covers reset, scoring wrap, serve, stale timer guard, hit/miss priority.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       timer_up = 1'b0;
    logic       timer_start;
    logic       gra_still;
    logic [1:0] game_state;
    logic [2:0] balls_left;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
`ifdef PONG_HISCORE_EN
    logic [3:0] hiscore_d1;
    logic [3:0] hiscore_d0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pong_game_ctrl #(.BALLS(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn         (btn),
        .hit         (hit),
        .miss        (miss),
        .timer_up    (timer_up),
        .timer_start (timer_start),
        .gra_still   (gra_still),
        .game_state  (game_state),
        .balls_left  (balls_left),
`ifdef PONG_HISCORE_EN
        .hiscore_d1  (hiscore_d1),
        .hiscore_d0  (hiscore_d0),
`endif
        .score_d1    (score_d1),
        .score_d0    (score_d0)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (game_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", game_state); end
        n_cmp++;
        if (gra_still !== 1'b1) begin n_err++; $display("FAIL reset_still got %0b want 1", gra_still); end
        n_cmp++;
        if (timer_start !== 1'b0) begin n_err++; $display("FAIL reset_tstart got %0b want 0", timer_start); end
        n_cmp++;
        if (balls_left !== 3'd3) begin n_err++; $display("FAIL reset_balls got %0d want 3", balls_left); end
        n_cmp++;
        if ({score_d1, score_d0} !== 8'h00) begin n_err++; $display("FAIL reset_score got %h want 00", {score_d1, score_d0}); end
        reset_n = 1'b1;
        step();
        btn = 2'b01;
        step();
        n_cmp++;
        if (game_state !== 2'd1) begin n_err++; $display("FAIL start_state got %0d want 1", game_state); end
        n_cmp++;
        if (balls_left !== 3'd2) begin n_err++; $display("FAIL start_balls got %0d want 2", balls_left); end
        n_cmp++;
        if (gra_still !== 1'b0) begin n_err++; $display("FAIL start_still got %0b want 0", gra_still); end
        btn = 2'b00;
        step();
    endtask

    task automatic test_score_wrap();
        logic [7:0] exp;
        for (int i = 1; i <= 100; i++) begin
            hit = 1'b1;
            step();
            exp = {4'((i % 100) / 10), 4'(i % 10)};
            n_cmp++;
            if ({score_d1, score_d0} !== exp) begin
                n_err++;
                $display("FAIL score_%0d got %h want %h", i, {score_d1, score_d0}, exp);
            end
        end
        hit = 1'b0;
        step();
        n_cmp++;
        if (game_state !== 2'd1) begin n_err++; $display("FAIL wrap_state got %0d want 1", game_state); end
    endtask

    task automatic test_hit_miss_same();
        hit = 1'b1;
        miss = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b0;
        n_cmp++;
        if ({score_d1, score_d0} !== 8'h01) begin n_err++; $display("FAIL hm_score got %h want 01", {score_d1, score_d0}); end
        n_cmp++;
        if (game_state !== 2'd1) begin n_err++; $display("FAIL hm_state got %0d want 1", game_state); end
        n_cmp++;
        if (balls_left !== 3'd2) begin n_err++; $display("FAIL hm_balls got %0d want 2", balls_left); end
        n_cmp++;
        if (timer_start !== 1'b0) begin n_err++; $display("FAIL hm_tstart got %0b want 0", timer_start); end
    endtask

    task automatic test_miss_serve();
        miss = 1'b1;
        step();
        miss = 1'b0;
        n_cmp++;
        if (game_state !== 2'd2) begin n_err++; $display("FAIL miss_state got %0d want 2", game_state); end
        n_cmp++;
        if (timer_start !== 1'b1) begin n_err++; $display("FAIL miss_tstart got %0b want 1", timer_start); end
        n_cmp++;
        if (balls_left !== 3'd1) begin n_err++; $display("FAIL miss_balls got %0d want 1", balls_left); end
        n_cmp++;
        if (gra_still !== 1'b1) begin n_err++; $display("FAIL miss_still got %0b want 1", gra_still); end
        step();
        n_cmp++;
        if (timer_start !== 1'b0) begin n_err++; $display("FAIL tstart_pulse got %0b want 0", timer_start); end
        btn = 2'b10;
        step();
        btn = 2'b00;
        n_cmp++;
        if (game_state !== 2'd2) begin n_err++; $display("FAIL early_btn got %0d want 2", game_state); end
        step();
        timer_up = 1'b1;
        step();
        n_cmp++;
        if (game_state !== 2'd2) begin n_err++; $display("FAIL no_queue got %0d want 2", game_state); end
        btn = 2'b01;
        step();
        btn = 2'b00;
        timer_up = 1'b0;
        n_cmp++;
        if (game_state !== 2'd1) begin n_err++; $display("FAIL serve_state got %0d want 1", game_state); end
        n_cmp++;
        if (gra_still !== 1'b0) begin n_err++; $display("FAIL serve_still got %0b want 0", gra_still); end
        step();
    endtask

    task automatic test_stale_over();
        timer_up = 1'b1;
        miss = 1'b1;
        step();
        miss = 1'b0;
        btn = 2'b01;
        step();
        btn = 2'b00;
        n_cmp++;
        if (game_state !== 2'd2) begin n_err++; $display("FAIL stale_nb got %0d want 2", game_state); end
        step();
        btn = 2'b01;
        step();
        btn = 2'b00;
        n_cmp++;
        if (balls_left !== 3'd0) begin n_err++; $display("FAIL last_ball got %0d want 0", balls_left); end
        miss = 1'b1;
        step();
        miss = 1'b0;
        n_cmp++;
        if (game_state !== 2'd3) begin n_err++; $display("FAIL over_state got %0d want 3", game_state); end
        n_cmp++;
        if (timer_start !== 1'b1) begin n_err++; $display("FAIL over_tstart got %0b want 1", timer_start); end
        n_cmp++;
        if (balls_left !== 3'd0) begin n_err++; $display("FAIL over_balls got %0d want 0", balls_left); end
        step();
        n_cmp++;
        if (game_state !== 2'd3) begin n_err++; $display("FAIL stale_over got %0d want 3", game_state); end
        step();
        timer_up = 1'b0;
        n_cmp++;
        if (game_state !== 2'd0) begin n_err++; $display("FAIL over_exit got %0d want 0", game_state); end
        n_cmp++;
        if ({score_d1, score_d0} !== 8'h00) begin n_err++; $display("FAIL over_clr got %h want 00", {score_d1, score_d0}); end
        n_cmp++;
        if (balls_left !== 3'd3) begin n_err++; $display("FAIL over_reload got %0d want 3", balls_left); end
        n_cmp++;
        if (gra_still !== 1'b1) begin n_err++; $display("FAIL over_still got %0b want 1", gra_still); end
        step();
    endtask

    task automatic test_ignore_outside_play();
        hit = 1'b1;
        miss = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b0;
        n_cmp++;
        if ({game_state, balls_left, score_d1, score_d0} !== {2'd0, 3'd3, 8'h00}) begin
            n_err++;
            $display("FAIL idle_hm got %h want %h", {game_state, balls_left, score_d1, score_d0}, {2'd0, 3'd3, 8'h00});
        end
    endtask

    task automatic test_async_reset();
        btn = 2'b01;
        step();
        btn = 2'b00;
        hit = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b1;
        step();
        miss = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (game_state !== 2'd0) begin n_err++; $display("FAIL arst_state got %0d want 0", game_state); end
        n_cmp++;
        if (timer_start !== 1'b0) begin n_err++; $display("FAIL arst_tstart got %0b want 0", timer_start); end
        n_cmp++;
        if ({score_d1, score_d0} !== 8'h00) begin n_err++; $display("FAIL arst_score got %h want 00", {score_d1, score_d0}); end
        step();
        reset_n = 1'b1;
        step();
    endtask

`ifdef PONG_HISCORE_EN
    task automatic play_game(input int hits);
        btn = 2'b01;
        step();
        btn = 2'b00;
        for (int i = 0; i < hits; i++) begin
            hit = 1'b1;
            step();
        end
        hit = 1'b0;
        for (int m = 0; m < 2; m++) begin
            miss = 1'b1;
            step();
            miss = 1'b0;
            timer_up = 1'b1;
            step();
            btn = 2'b01;
            step();
            btn = 2'b00;
            timer_up = 1'b0;
            step();
        end
        miss = 1'b1;
        step();
        miss = 1'b0;
        timer_up = 1'b1;
        step();
        step();
        timer_up = 1'b0;
        step();
    endtask

    task automatic test_hiscore();
        play_game(5);
        n_cmp++;
        if ({hiscore_d1, hiscore_d0} !== 8'h05) begin n_err++; $display("FAIL hi_g1 got %h want 05", {hiscore_d1, hiscore_d0}); end
        play_game(3);
        n_cmp++;
        if ({hiscore_d1, hiscore_d0} !== 8'h05) begin n_err++; $display("FAIL hi_g2 got %h want 05", {hiscore_d1, hiscore_d0}); end
        n_cmp++;
        if (game_state !== 2'd0) begin n_err++; $display("FAIL hi_idle got %0d want 0", game_state); end
        btn = 2'b01;
        step();
        btn = 2'b00;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({hiscore_d1, hiscore_d0} !== 8'h00) begin n_err++; $display("FAIL hi_rst got %h want 00", {hiscore_d1, hiscore_d0}); end
        n_cmp++;
        if (game_state !== 2'd0) begin n_err++; $display("FAIL hi_rst_state got %0d want 0", game_state); end
        step();
        reset_n = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_score_wrap();
        test_hit_miss_same();
        test_miss_serve();
        test_stale_over();
        test_ignore_outside_play();
        test_async_reset();
`ifdef PONG_HISCORE_EN
        test_hiscore();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
